// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: filtered clock, 11-bit frame FSM, E0/F0 prefix decode.
// Optional partial-frame timeout is built when PS2_TIMEOUT_EN is defined.
module ps2_receiver #(
  parameter int unsigned FILTER  = 8,
  parameter logic [15:0] TIMEOUT = 16'd2000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic [1:0]  ps2,
  output logic [10:0] ps2_key,
  output logic        error
);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e            r_state;
  logic [FILTER-1:0] r_filt;
  logic              r_clk_f;
  logic              r_data;
  logic [2:0]        r_cnt;
  logic [7:0]        r_shift;
  logic              r_par;
  logic              r_ext;
  logic              r_rel;

  logic              w_fall;
  logic              w_odd;
  logic              w_drop;

  // Edge is seen on the ce cycle where the filter first reads all zeros.
  assign w_fall = r_clk_f & ~(|r_filt);
  assign w_odd  = ^{r_shift, r_par};

  always_comb begin
    w_drop = 1'b0;
    case (r_shift)
      8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: w_drop = 1'b1;
      default: w_drop = 1'b0;
    endcase
  end

`ifdef PS2_TIMEOUT_EN
  logic [15:0] r_to;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StIdle;
      r_filt  <= '1;
      r_clk_f <= 1'b1;
      r_data  <= 1'b1;
      r_cnt   <= 3'd0;
      r_shift <= 8'd0;
      r_par   <= 1'b0;
      r_ext   <= 1'b0;
      r_rel   <= 1'b0;
      ps2_key <= 11'd0;
      error   <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      r_to    <= 16'd0;
`endif
    end else begin
      error <= 1'b0;
      if (ce) begin
        r_filt <= {r_filt[FILTER-2:0], ps2[0]};
        r_data <= ps2[1];
        if (&r_filt) begin
          r_clk_f <= 1'b1;
        end else if (~(|r_filt)) begin
          r_clk_f <= 1'b0;
        end

        if (w_fall) begin
          case (r_state)
            StIdle: begin
              if (!r_data) begin
                r_state <= StData;
                r_cnt   <= 3'd0;
              end
            end
            StData: begin
              r_shift <= {r_data, r_shift[7:1]};
              r_cnt   <= r_cnt + 3'd1;
              if (r_cnt == 3'd7) r_state <= StParity;
            end
            StParity: begin
              r_par   <= r_data;
              r_state <= StStop;
            end
            StStop: begin
              r_state <= StIdle;
              if (r_data && w_odd) begin
                if (r_shift == 8'hE0) begin
                  r_ext <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                  r_rel <= 1'b1;
                end else begin
                  r_ext <= 1'b0;
                  r_rel <= 1'b0;
                  if (!w_drop) ps2_key <= {~ps2_key[10], ~r_rel, r_ext, r_shift};
                end
              end else begin
                error <= 1'b1;
                r_ext <= 1'b0;
                r_rel <= 1'b0;
              end
            end
            default: r_state <= StIdle;
          endcase
        end

`ifdef PS2_TIMEOUT_EN
        if (w_fall || r_state == StIdle) begin
          r_to <= 16'd0;
        end else if (r_to == TIMEOUT - 16'd1) begin
          r_to    <= 16'd0;
          r_state <= StIdle;
          error   <= 1'b1;
          r_ext   <= 1'b0;
          r_rel   <= 1'b0;
        end else begin
          r_to <= r_to + 16'd1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: frame decode, prefixes, errors, glitch, reset, timeout.
module tb_ps2_receiver;

`ifdef PS2_TIMEOUT_EN
  localparam int unsigned FILT = 4;
  localparam int HALF = 6;
`else
  localparam int unsigned FILT = 8;
  localparam int HALF = 12;
`endif
  localparam logic [15:0] TO = 16'd16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ce    = 1'b0;
  logic [1:0]  ps2   = 2'b11;
  logic [10:0] ps2_key;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int err_run  = 0;
  int long_err = 0;
  int tog_cnt  = 0;
  logic prev_t = 1'b0;
  int e0, t0;

  ps2_receiver #(.FILTER(FILT), .TIMEOUT(TO)) dut (
    .clock   (clock),
    .reset   (reset),
    .ce      (ce),
    .ps2     (ps2),
    .ps2_key (ps2_key),
    .error   (error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (error === 1'b1) begin
      err_cnt++;
      err_run++;
      if (err_run > 1) long_err = 1;
    end else begin
      err_run = 0;
    end
    if (ps2_key[10] !== prev_t) tog_cnt++;
    prev_t = ps2_key[10];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic ce_ticks(input int n);
    repeat (n) begin
      @(negedge clock) ce = 1'b1;
      @(negedge clock) ce = 1'b0;
    end
  endtask

  task automatic send_bit(input logic b);
    ps2 = {b, 1'b1};
    ce_ticks(HALF);
    ps2[0] = 1'b0;
    ce_ticks(HALF);
  endtask

  task automatic idle_line();
    ps2 = 2'b11;
    ce_ticks(HALF);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    idle_line();
  endtask

  // Well-formed frame with odd parity.
  task automatic good(input logic [7:0] d);
    send_frame(d, ~(^d), 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clock) reset = 1'b1;
    ps2 = 2'b11;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic [10:0] bits;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    ce_ticks(4);
    check("reset_key", 32'(ps2_key), 32'h000);
    check("reset_err", 32'(err_cnt), 0);

    t0 = tog_cnt;
    good(8'h1C);
    check("make_1c", 32'(ps2_key), 32'h61C);
    check("make_1c_tog", 32'(tog_cnt - t0), 1);
    check("make_1c_err", 32'(err_cnt), 0);

    t0 = tog_cnt;
    good(8'hE0);
    good(8'hF0);
    check("prefix_no_event", 32'(tog_cnt - t0), 0);
    good(8'h74);
    check("ext_rel_74", 32'(ps2_key), 32'h174);
    check("ext_rel_tog", 32'(tog_cnt - t0), 1);

    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    check("bad_parity_err", 32'(err_cnt - e0), 1);
    check("bad_parity_key", 32'(ps2_key), 32'h174);
    send_frame(8'h16, 1'b0, 1'b0);
    check("bad_stop_err", 32'(err_cnt - e0), 2);
    check("err_one_clock", 32'(long_err), 0);

    good(8'hF0);
    send_frame(8'h1C, 1'b1, 1'b1);
    good(8'h1C);
    check("err_clears_rel", 32'(ps2_key), 32'h61C);

    t0 = tog_cnt;
    good(8'hE0);
    good(8'hAA);
    check("drop_aa", 32'(tog_cnt - t0), 0);
    good(8'h1C);
    check("drop_clears_ext", 32'(ps2_key), 32'h21C);

    e0 = err_cnt;
    ps2 = 2'b10;
    ce_ticks(3);
    idle_line();
    idle_line();
    good(8'h16);
    check("glitch_key", 32'(ps2_key), 32'h616);
    check("glitch_err", 32'(err_cnt - e0), 0);

    send_bit(1'b1);
    idle_line();
    good(8'h1C);
    check("bad_start_key", 32'(ps2_key), 32'h21C);
    check("bad_start_err", 32'(err_cnt - e0), 0);

    t0 = tog_cnt;
    good(8'h1C);
    check("b2b_first", 32'(ps2_key), 32'h61C);
    good(8'h1C);
    check("b2b_second", 32'(ps2_key), 32'h21C);
    check("b2b_tog", 32'(tog_cnt - t0), 2);

    e0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    do_reset();
    ce_ticks(4);
    check("midreset_key", 32'(ps2_key), 32'h000);
    check("midreset_err", 32'(err_cnt - e0), 0);
    good(8'h1C);
    check("midreset_next", 32'(ps2_key), 32'h61C);

    // Frame 0x16 bits in wire order: start, d0..d7, parity, stop.
    bits = {1'b1, 1'b0, 8'h16, 1'b0};
    e0 = err_cnt;
    for (int i = 0; i < 4; i++) send_bit(bits[i]);
    ps2 = 2'b11;
    ce_ticks(40);
`ifdef PS2_TIMEOUT_EN
    check("timeout_err", 32'(err_cnt - e0), 1);
    check("timeout_key", 32'(ps2_key), 32'h61C);
    good(8'h16);
    check("timeout_next", 32'(ps2_key), 32'h216);
`else
    check("stall_no_err", 32'(err_cnt - e0), 0);
    for (int i = 4; i < 11; i++) send_bit(bits[i]);
    idle_line();
    check("stall_resume", 32'(ps2_key), 32'h216);
`endif
    check("err_one_clock_end", 32'(long_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
